// File: rtl/uart_pkg.sv
// Shared types and constants for the robot serial link receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Integer division on purpose: the small baud error is absorbed by mid-bit sampling.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic first-word-fall-through FIFO; a pop on a full FIFO frees room for a same-cycle push.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_json_rx.sv
// 8N1 receiver for the robot serial link: mid-bit sampling into a FWFT byte FIFO with line-feed framing pulses.
module uart_json_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       line_done,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             rx_meta_q, rx_s_q, rx_d_q;
  logic             push_q, line_done_q, frame_err_q, overflow_q;
  logic             fifo_full, fifo_empty, room;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  // The push lands one cycle after the stop sample, so a pop seen now guarantees a slot then.
  assign room = ~fifo_full | (m_valid & m_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      line_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      line_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_d_q && !rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == CNT_W'(HALF - 1)) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_W'(CPB - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == CNT_W'(CPB - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!rx_s_q) begin
              frame_err_q <= 1'b1;
            end else if (room) begin
              push_q      <= 1'b1;
              line_done_q <= (shift_q == ASCII_LF);
            end else begin
              overflow_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_q),
    .push_data_i(shift_q),
    .full_o     (fifo_full),
    .pop_i      (m_ready),
    .pop_data_o (m_data),
    .empty_o    (fifo_empty)
  );

  assign m_valid   = ~fifo_empty;
  assign line_done = line_done_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE);

endmodule
